alu_mdu_ctrl: RTL and testbench
===============================

ALU_MDU_CTRL -- requirements
Module: alu_mdu_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (even, >=8).
REQ-002 SHALL have parameter CTL_W, default 4, ALU control code width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ALUOp  input  2  main-decoder op class.
REQ-006 SHALL have port Funct  input  6  R-type funct field.
REQ-007 SHALL have port start  input  1  instruction valid in EX this cycle.
REQ-008 SHALL have port a, b  input  WIDTH each  rs/rt operands.
REQ-009 SHALL have port ALUInput  output  CTL_W  ALU control code (combinational).
REQ-010 SHALL have port illegal  output  1  undecodable ALUOp/Funct pair.
REQ-011 SHALL have port stall  output  1  hold pipeline; EX instruction not accepted.
REQ-012 SHALL have port done  output  1  one-cycle pulse: HI/LO just written.
REQ-013 SHALL have ports hi, lo  output  WIDTH each  registered HI/LO.
REQ-014 SHALL have port mdu_result  output  WIDTH  HI for MFHI, LO for MFLO, else 0.

Function
REQ-015 Decode SHALL be: ALUOp 00 -> 0010 (add); 01 -> 0110 (sub); 11 -> 1111 with illegal=1.
REQ-016 ALUOp 10 SHALL map Funct 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100.
REQ-017 ALUOp 10 with Funct 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010010 MFLO SHALL give ALUInput 0010 and illegal=0; any other Funct SHALL give 1111, illegal=1.
REQ-018 Decode SHALL be fully specified; no X outputs for any input value.
REQ-019 FSM states SHALL be IDLE, BUSY, DONE.
REQ-020 IDLE or DONE with start=1 and an MDU op (MULT..DIVU) SHALL latch a, b, op on that edge and enter BUSY, iteration count=0.
REQ-021 BUSY SHALL perform one shift-add (multiply) or restoring-subtract (divide) step per cycle on magnitudes; after WIDTH steps SHALL enter DONE.
REQ-022 Entry into DONE SHALL write hi/lo on that edge; done=1 for exactly the DONE cycle; DONE without new start SHALL return to IDLE.
REQ-023 Latency: done SHALL be high exactly WIDTH+1 cycles after the accepting edge (33 for WIDTH=32).
REQ-024 Multiply SHALL produce {hi,lo} = 2*WIDTH-bit product; signed ops by sign correction of magnitude result.
REQ-025 Divide SHALL produce lo=quotient, hi=remainder; signed: quotient truncates toward zero, remainder takes dividend sign.
REQ-026 Divide by zero SHALL complete with normal latency, lo=all ones, hi=dividend a; no other flag.
REQ-027 Signed DIV of most-negative by -1 SHALL give lo=most-negative, hi=0.
REQ-028 stall SHALL be 1 when start=1 with MDU op, MFHI or MFLO and state=BUSY; otherwise 0.
REQ-029 Stalled start SHALL not be latched; it is accepted on the first non-BUSY cycle.
REQ-030 MFHI/MFLO in DONE cycle SHALL return the newly written hi/lo.
REQ-031 Non-MDU instructions SHALL never stall and SHALL not disturb FSM, hi, lo.

Reset
REQ-032 reset=1 SHALL force IDLE, hi=lo=0, count=0, done=0, stall=0, discarding any in-flight op.
REQ-033 reset SHALL take priority over start on the same edge.

Structure
REQ-034 Package alu_pkg SHALL hold ALUOp encodings, Funct constants, ALU control codes, FSM state type.
REQ-035 Iterative engine SHALL be sub-module mdu_core (operands, op, start in; hi, lo, finish out); decode and FSM stay in alu_mdu_ctrl.

Verification (WIDTH=32)
REQ-036 Decode sweep all ALUOp x Funct -> codes per REQ-015..017, illegal=1 exactly on unlisted pairs.
REQ-037 MULT a=FFFFFFFD b=7 -> hi=FFFFFFFF lo=FFFFFFEB, done 33 cycles after accept.
REQ-038 DIVU a=100 b=7 -> lo=14 hi=2; DIV a=-7 b=2 -> lo=FFFFFFFD hi=FFFFFFFF.
REQ-039 DIV a=5 b=0 -> lo=FFFFFFFF hi=5 at cycle 33.
REQ-040 MFLO issued 5 cycles after MULT accept -> stall=1 until DONE, mdu_result equals new lo in DONE cycle.
REQ-041 reset at BUSY cycle 10 -> IDLE, hi=lo=0, no done pulse; next MULTU 3x4 -> lo=12 after 33 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control decoder and the multiply/divide unit:
// main-decoder op classes, R-type funct values, ALU control codes and FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_BAD   = 2'b11
  } aluop_e;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;
  localparam logic [3:0] CTL_BAD = 4'b1111;

  // Low two funct bits of MULT..DIVU select the operation directly.
  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic [3:0] ctl;
    logic       illegal;
  } decode_t;

  function automatic logic is_mdu_funct(input logic [5:0] funct);
    return funct[5:2] == F_MULT[5:2];
  endfunction

  function automatic logic is_mf_funct(input logic [5:0] funct);
    return (funct == F_MFHI) || (funct == F_MFLO);
  endfunction

  function automatic decode_t alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
    decode_t d;
    d.ctl     = CTL_BAD;
    d.illegal = 1'b1;
    case (aluop_e'(alu_op))
      ALUOP_ADD: d = '{ctl: CTL_ADD, illegal: 1'b0};
      ALUOP_SUB: d = '{ctl: CTL_SUB, illegal: 1'b0};
      ALUOP_RTYPE: begin
        case (funct)
          F_ADD:   d = '{ctl: CTL_ADD, illegal: 1'b0};
          F_SUB:   d = '{ctl: CTL_SUB, illegal: 1'b0};
          F_AND:   d = '{ctl: CTL_AND, illegal: 1'b0};
          F_OR:    d = '{ctl: CTL_OR,  illegal: 1'b0};
          F_SLT:   d = '{ctl: CTL_SLT, illegal: 1'b0};
          F_NOR:   d = '{ctl: CTL_NOR, illegal: 1'b0};
          F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO:
                   d = '{ctl: CTL_ADD, illegal: 1'b0};
          default: d = '{ctl: CTL_BAD, illegal: 1'b1};
        endcase
      end
      default: d = '{ctl: CTL_BAD, illegal: 1'b1};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Iterative multiply/divide engine: one shift-add or restoring-subtract step per
// cycle on operand magnitudes, with sign correction applied to the final result.
module mdu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  mdu_op_e          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_finish
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  logic             r_busy;
  logic [CNT_W-1:0] r_count;
  logic             r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_b_zero;
  logic [WIDTH-1:0] r_upper;
  logic [WIDTH-1:0] r_lower;
  logic [WIDTH-1:0] r_mb;
  logic [WIDTH-1:0] r_a;

  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_step;
  logic             w_ge;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  assign w_signed = (i_op == MDU_MULT) || (i_op == MDU_DIV);
  assign w_a_neg  = w_signed && i_a[WIDTH-1];
  assign w_b_neg  = w_signed && i_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~i_a + 1'b1) : i_a;
  assign w_b_mag  = w_b_neg ? (~i_b + 1'b1) : i_b;

  assign o_finish = r_busy && (r_count == LAST);
  assign w_step   = r_busy && !o_finish;

  // Multiply: {upper,lower} holds partial product and unconsumed multiplier bits.
  assign w_sum   = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_mb} : '0);
  // Divide: upper is the partial remainder, lower shifts dividend out / quotient in.
  assign w_shift = {r_upper, r_lower[WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_mb};
  assign w_diff  = w_shift[WIDTH-1:0] - r_mb;

  // NOTE: clocked state is written with non-blocking '<=' so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_count <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_count <= '0;
    end else if (o_finish) begin
      r_busy  <= 1'b0;
    end else if (r_busy) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on i_start
  // before anything reads them, and o_hi/o_lo are only captured on o_finish.
  always_ff @(posedge clk) begin
    if (i_start) begin
      r_div    <= (i_op == MDU_DIV) || (i_op == MDU_DIVU);
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_b_zero <= (i_b == '0);
      r_a      <= i_a;
      r_mb     <= w_b_mag;
      r_upper  <= '0;
      r_lower  <= w_a_mag;
    end else if (w_step) begin
      if (r_div) begin
        r_upper <= w_ge ? w_diff : w_shift[WIDTH-1:0];
        r_lower <= {r_lower[WIDTH-2:0], w_ge};
      end else begin
        r_upper <= w_sum[WIDTH:1];
        r_lower <= {w_sum[0], r_lower[WIDTH-1:1]};
      end
    end
  end

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_hi = '0;
    o_lo = '0;
    if (!r_div) begin
      {o_hi, o_lo} = r_neg_q ? -{r_upper, r_lower} : {r_upper, r_lower};
    end else if (r_b_zero) begin
      o_hi = r_a;
      o_lo = '1;
    end else begin
      o_lo = r_neg_q ? -r_lower : r_lower;
      o_hi = r_neg_r ? -r_upper : r_upper;
    end
  end

endmodule

// File: rtl/alu_mdu_ctrl.sv
// ALU control decoder plus the IDLE/BUSY/DONE sequencer that owns HI/LO and
// stalls the pipeline while the multiply/divide engine is iterating.
module alu_mdu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CTL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [CTL_W-1:0] ALUInput,
  output logic             illegal,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mdu_result
);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  decode_t          w_dec;
  logic             w_rtype;
  logic             w_mdu_op;
  logic             w_mf;
  logic             w_accept;
  logic             w_core_finish;
  logic [WIDTH-1:0] w_core_hi;
  logic [WIDTH-1:0] w_core_lo;

  assign w_dec    = alu_decode(ALUOp, Funct);
  assign ALUInput = CTL_W'(w_dec.ctl);
  assign illegal  = w_dec.illegal;

  assign w_rtype  = (ALUOp == ALUOP_RTYPE);
  assign w_mdu_op = w_rtype && is_mdu_funct(Funct);
  assign w_mf     = w_rtype && is_mf_funct(Funct);

  // A waiting MDU op is taken in DONE too, so back-to-back ops lose no cycle.
  assign w_accept = start && w_mdu_op && (r_state != ST_BUSY);
  assign stall    = !reset && start && (w_mdu_op || w_mf) && (r_state == ST_BUSY);
  assign done     = (r_state == ST_DONE);
  assign hi       = r_hi;
  assign lo       = r_lo;

  mdu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_accept),
    .i_op     (mdu_op_e'(Funct[1:0])),
    .i_a      (a),
    .i_b      (b),
    .o_hi     (w_core_hi),
    .o_lo     (w_core_lo),
    .o_finish (w_core_finish)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_BUSY;
      ST_BUSY: if (w_core_finish) w_state_next = ST_DONE;
      ST_DONE: w_state_next = w_accept ? ST_BUSY : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if ((r_state == ST_BUSY) && w_core_finish) begin
      r_hi <= w_core_hi;
      r_lo <= w_core_lo;
    end
  end

  always_comb begin
    mdu_result = '0;
    if (w_rtype && (Funct == F_MFHI)) begin
      mdu_result = r_hi;
    end else if (w_rtype && (Funct == F_MFLO)) begin
      mdu_result = r_lo;
    end
  end

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Self-checking bench for alu_mdu_ctrl at WIDTH=32: decode sweep, directed and
// random multiply/divide against a plain-arithmetic model, stall and reset cases.
module tb_alu_mdu_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   ALUOp;
  logic [5:0]   Funct;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   ALUInput;
  logic         illegal;
  logic         stall;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] mdu_result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_mdu_ctrl #(
    .WIDTH(W),
    .CTL_W(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ALUOp      (ALUOp),
    .Funct      (Funct),
    .start      (start),
    .a          (a),
    .b          (b),
    .ALUInput   (ALUInput),
    .illegal    (illegal),
    .stall      (stall),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .mdu_result (mdu_result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {ALUInput, illegal} straight from the decode table.
  function automatic logic [4:0] dec_model(input logic [1:0] op, input logic [5:0] fn);
    case (op)
      2'b00: return {4'b0010, 1'b0};
      2'b01: return {4'b0110, 1'b0};
      2'b10: begin
        case (fn)
          6'b100000: return {4'b0010, 1'b0};
          6'b100010: return {4'b0110, 1'b0};
          6'b100100: return {4'b0000, 1'b0};
          6'b100101: return {4'b0001, 1'b0};
          6'b101010: return {4'b0111, 1'b0};
          6'b100111: return {4'b1100, 1'b0};
          6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b010000, 6'b010010:
                     return {4'b0010, 1'b0};
          default:   return {4'b1111, 1'b1};
        endcase
      end
      default: return {4'b1111, 1'b1};
    endcase
  endfunction

  // Expected {hi, lo} from native 64-bit / 32-bit arithmetic.
  function automatic logic [63:0] mdu_model(input logic [5:0] fn, input logic [31:0] av,
                                            input logic [31:0] bv);
    longint p;
    int     q;
    int     r;
    case (fn)
      6'b011000: begin
        p = longint'($signed(av)) * longint'($signed(bv));
        return p;
      end
      6'b011001: return {32'd0, av} * {32'd0, bv};
      6'b011010: begin
        if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
        if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(av) / $signed(bv);
        r = $signed(av) % $signed(bv);
        return {r, q};
      end
      6'b011011: begin
        if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
        return {av % bv, av / bv};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0;
    ALUOp = 2'b00;
    Funct = 6'd0;
  endtask

  // Cycles until done rises, counted from the cycle after the accepting edge; 41 = never.
  task automatic wait_done(output int n);
    bit got;
    got = 1'b0;
    n   = 41;
    for (int i = 1; i <= 40 && !got; i++) begin
      cyc();
      if (done === 1'b1) begin
        n   = i;
        got = 1'b1;
      end
    end
  endtask

  task automatic issue(input logic [5:0] fn, input logic [31:0] av, input logic [31:0] bv);
    cyc();
    ALUOp = 2'b10;
    Funct = fn;
    a     = av;
    b     = bv;
    start = 1'b1;
    #1;
    check("issue_stall", stall, 1'b0);
    cyc();
    idle_inputs();
  endtask

  task automatic run_mdu(input logic [5:0] fn, input logic [31:0] av, input logic [31:0] bv,
                         input string tag);
    logic [63:0] exp;
    int          n;
    exp = mdu_model(fn, av, bv);
    issue(fn, av, bv);
    check({tag, "_busy"}, done, 1'b0);
    wait_done(n);
    check({tag, "_latency"}, n, 33);
    check({tag, "_hi"}, hi, exp[63:32]);
    check({tag, "_lo"}, lo, exp[31:0]);
    cyc();
    check({tag, "_pulse"}, done, 1'b0);
  endtask

  initial begin
    logic [63:0] exp;
    logic [63:0] exp2;
    int          n;
    bit          got;
    bit          bad;
    logic [5:0]  fn;
    logic [31:0] av;
    logic [31:0] bv;

    // Reset held while a MULT is offered: reset wins, nothing starts.
    reset = 1'b1;
    a     = 32'd9;
    b     = 32'd9;
    ALUOp = 2'b10;
    Funct = 6'b011000;
    start = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    idle_inputs();
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_done", done, 1'b0);
    check("rst_stall", stall, 1'b0);
    wait_done(n);
    check("rst_prio_no_done", n, 41);

    for (int op = 0; op < 4; op++) begin
      for (int f = 0; f < 64; f++) begin
        ALUOp = 2'(op);
        Funct = 6'(f);
        #1;
        check($sformatf("dec_%0d_%02h", op, f), {ALUInput, illegal}, dec_model(2'(op), 6'(f)));
      end
    end
    idle_inputs();

    run_mdu(6'b011000, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    run_mdu(6'b011011, 32'd100, 32'd7, "divu_100_7");
    run_mdu(6'b011010, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_mdu(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    run_mdu(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_mdu(6'b011011, 32'hDEAD_BEEF, 32'd0, "divu_zero");
    run_mdu(6'b011010, 32'd5, 32'd0, "div_5_0");

    ALUOp = 2'b10;
    Funct = 6'b010000;
    #1;
    check("mfhi_read", mdu_result, 32'd5);
    Funct = 6'b010010;
    #1;
    check("mflo_read", mdu_result, 32'hFFFF_FFFF);
    Funct = 6'b100000;
    #1;
    check("add_result_zero", mdu_result, 32'd0);

    // Ordinary ALU instructions leave the MDU alone.
    start = 1'b1;
    repeat (3) begin
      cyc();
      check("alu_idle_stall", stall, 1'b0);
      check("alu_idle_done", done, 1'b0);
    end
    check("alu_keep_hi", hi, 32'd5);
    check("alu_keep_lo", lo, 32'hFFFF_FFFF);
    idle_inputs();

    for (int t = 0; t < 12; t++) begin
      fn = {4'b0110, 2'($urandom_range(0, 3))};
      av = $urandom;
      case ($urandom_range(0, 3))
        0:       bv = 32'd0;
        1:       bv = $urandom_range(1, 300);
        2:       bv = $urandom;
        default: begin
          av = 32'h8000_0000;
          bv = $urandom;
        end
      endcase
      run_mdu(fn, av, bv, $sformatf("rand%0d", t));
    end

    // MFLO five cycles after a MULT waits, then sees the new LO in the DONE cycle.
    exp = mdu_model(6'b011000, 32'h0012_D687, 32'hFFFF_FFA7);
    issue(6'b011000, 32'h0012_D687, 32'hFFFF_FFA7);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      ALUOp = 2'b10;
      Funct = 6'b100000;
      start = 1'b1;
      #1;
      check("busy_alu_nostall", stall, 1'b0);
    end
    cyc();
    ALUOp = 2'b10;
    Funct = 6'b010010;
    start = 1'b1;
    #1;
    check("mflo_stall_c5", stall, 1'b1);
    n   = 5;
    got = 1'b0;
    bad = 1'b0;
    while (!got && n < 40) begin
      cyc();
      n++;
      if (done === 1'b1) got = 1'b1;
      else if (stall !== 1'b1) bad = 1'b1;
    end
    check("mflo_done_cycle", n, 33);
    check("mflo_stall_held", bad, 1'b0);
    check("mflo_done_stall", stall, 1'b0);
    check("mflo_result", mdu_result, exp[31:0]);
    idle_inputs();
    cyc();
    check("mflo_pulse", done, 1'b0);

    // A DIV offered while busy is held off and taken in the DONE cycle.
    exp  = mdu_model(6'b011001, 32'h0001_0001, 32'h0000_FFFF);
    exp2 = mdu_model(6'b011010, 32'hFFFF_FC18, 32'd33);
    issue(6'b011001, 32'h0001_0001, 32'h0000_FFFF);
    repeat (3) cyc();
    ALUOp = 2'b10;
    Funct = 6'b011010;
    a     = 32'hFFFF_FC18;
    b     = 32'd33;
    start = 1'b1;
    #1;
    check("queued_stall", stall, 1'b1);
    n   = 3;
    got = 1'b0;
    while (!got && n < 40) begin
      cyc();
      n++;
      if (done === 1'b1) got = 1'b1;
    end
    check("queued_first_latency", n, 33);
    check("queued_first_hi", hi, exp[63:32]);
    check("queued_first_lo", lo, exp[31:0]);
    check("queued_accept_stall", stall, 1'b0);
    cyc();
    idle_inputs();
    check("queued_second_busy", done, 1'b0);
    wait_done(n);
    check("queued_second_latency", n, 33);
    check("queued_second_hi", hi, exp2[63:32]);
    check("queued_second_lo", lo, exp2[31:0]);

    // Reset at BUSY cycle 10 discards the op; the next MULTU runs normally.
    issue(6'b011000, 32'h0000_1234, 32'h0000_5678);
    repeat (9) cyc();
    reset = 1'b1;
    ALUOp = 2'b10;
    Funct = 6'b010010;
    start = 1'b1;
    #1;
    check("rst_busy_stall", stall, 1'b0);
    cyc();
    reset = 1'b0;
    idle_inputs();
    check("rst_busy_hi", hi, 32'd0);
    check("rst_busy_lo", lo, 32'd0);
    check("rst_busy_done", done, 1'b0);
    wait_done(n);
    check("rst_busy_no_done", n, 41);
    run_mdu(6'b011001, 32'd3, 32'd4, "post_rst_multu");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
